// File: rtl/ram_sp_fill.sv
// ram_sp_fill: single-port synchronous RAM with byte write enables, a 1- or
// 2-stage read pipeline with a valid strobe, and a fill engine that writes
// FILL_VALUE to every word after reset and whenever Clear_i is pulsed in IDLE.
//
// Optional feature macro: RAM_PARITY_EN
//   Defined   -> per-byte even parity stored on every write, checked on reads,
//                ParityError_o pulses together with Valid_o on a mismatch.
//   Undefined -> no parity storage, no ParityError_o port.
//
// Ports:
//   Clock          system clock, rising edge
//   Reset          asynchronous active-low reset
//   Request_i      access request, taken only while Ready_o=1
//   WriteEnable_i  1 = write, 0 = read
//   ByteEnable_i   per-byte write mask (ignored for reads)
//   Address_i      word address
//   Data_i         write data
//   Clear_i        pulse in IDLE starts a fill pass
//   Ready_o        1 = idle, accepting requests
//   Valid_o        one-cycle read-data strobe
//   Data_o         read data, held until the next read completes
//   ParityError_o  read parity mismatch (RAM_PARITY_EN only)
module ram_sp_fill #(
    parameter int                    ADDRESS_WIDTH = 10,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    READ_LATENCY  = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE    = 32'hFFFF_FFFF
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Request_i,
    input  logic                      WriteEnable_i,
    input  logic [DATA_WIDTH/8-1:0]   ByteEnable_i,
    input  logic [ADDRESS_WIDTH-1:0]  Address_i,
    input  logic [DATA_WIDTH-1:0]     Data_i,
    input  logic                      Clear_i,
    output logic                      Ready_o,
    output logic                      Valid_o,
    output logic [DATA_WIDTH-1:0]     Data_o
`ifdef RAM_PARITY_EN
   ,output logic                      ParityError_o
`endif
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    typedef enum logic {S_FILL = 1'b0, S_IDLE = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

    logic                     mem_we;
    logic [NB-1:0]            mem_be;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     rd_en;

    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FILL: begin
                cnt_d = cnt_q + 1'b1;          // wraps to 0 after the last word
                if (cnt_q == '1) state_d = S_IDLE;
            end
            default: begin
                // A request in the same cycle is still accepted below.
                if (Clear_i) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // ---------------- FSM: outputs / memory port mux ----------------
    always_comb begin
        Ready_o   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '1;
        mem_addr  = cnt_q;
        mem_wdata = FILL_VALUE;
        rd_en     = 1'b0;
        case (state_q)
            S_FILL: mem_we = 1'b1;
            default: begin
                Ready_o   = 1'b1;
                mem_be    = ByteEnable_i;
                mem_addr  = Address_i;
                mem_wdata = Data_i;
                mem_we    = Request_i & WriteEnable_i;
                rd_en     = Request_i & ~WriteEnable_i;
            end
        endcase
    end

    // ---------------- storage ----------------
    always_ff @(posedge Clock) begin
        if (mem_we)
            for (int b = 0; b < NB; b++)
                if (mem_be[b]) mem_q[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end

    logic                  fin_vld;
    logic [DATA_WIDTH-1:0] fin_data;

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] fin_par;

    function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
        for (int b = 0; b < NB; b++) byte_par[b] = ^d[b*8 +: 8];
    endfunction

    always_ff @(posedge Clock) begin
        if (mem_we)
            for (int b = 0; b < NB; b++)
                if (mem_be[b]) par_q[mem_addr][b] <= ^mem_wdata[b*8 +: 8];
    end
`endif

    // ---------------- read pipeline ----------------
    // The last stage always drives Data_o; READ_LATENCY=2 inserts one
    // register stage between the array and that last stage.
    generate
        if (READ_LATENCY == 2) begin : g_rl2
            logic                  s1_vld_q;
            logic [DATA_WIDTH-1:0] s1_data_q;
`ifdef RAM_PARITY_EN
            logic [NB-1:0]         s1_par_q;
`endif
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
`ifdef RAM_PARITY_EN
                    s1_par_q  <= '0;
`endif
                end else begin
                    s1_vld_q <= rd_en;
                    if (rd_en) begin
                        s1_data_q <= mem_q[mem_addr];
`ifdef RAM_PARITY_EN
                        s1_par_q  <= par_q[mem_addr];
`endif
                    end
                end
            end
            assign fin_vld  = s1_vld_q;
            assign fin_data = s1_data_q;
`ifdef RAM_PARITY_EN
            assign fin_par  = s1_par_q;
`endif
        end else begin : g_rl1
            assign fin_vld  = rd_en;
            assign fin_data = mem_q[mem_addr];
`ifdef RAM_PARITY_EN
            assign fin_par  = par_q[mem_addr];
`endif
        end
    endgenerate

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= fin_vld;
            if (fin_vld) data_q <= fin_data;
        end
    end

    assign Valid_o = valid_q;
    assign Data_o  = data_q;

`ifdef RAM_PARITY_EN
    logic perr_q;
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) perr_q <= 1'b0;
        else        perr_q <= fin_vld && (fin_par != byte_par(fin_data));
    end
    assign ParityError_o = perr_q;
`endif

endmodule

// File: tb/tb_ram_sp_fill.sv
module tb_ram_sp_fill;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        Request_i, WriteEnable_i, Clear_i;
    logic [3:0]  ByteEnable_i;
    logic [9:0]  Address_i;
    logic [31:0] Data_i;
    logic        r1, v1, r2, v2;
    logic [31:0] d1, d2;
`ifdef RAM_PARITY_EN
    logic        pe1, pe2;
`endif

    always #5 Clock = ~Clock;

    ram_sp_fill #(.READ_LATENCY(1)) u_l1 (
        .Clock(Clock), .Reset(Reset), .Request_i(Request_i), .WriteEnable_i(WriteEnable_i),
        .ByteEnable_i(ByteEnable_i), .Address_i(Address_i), .Data_i(Data_i), .Clear_i(Clear_i),
        .Ready_o(r1), .Valid_o(v1), .Data_o(d1)
`ifdef RAM_PARITY_EN
       ,.ParityError_o(pe1)
`endif
    );

    ram_sp_fill #(.READ_LATENCY(2)) u_l2 (
        .Clock(Clock), .Reset(Reset), .Request_i(Request_i), .WriteEnable_i(WriteEnable_i),
        .ByteEnable_i(ByteEnable_i), .Address_i(Address_i), .Data_i(Data_i), .Clear_i(Clear_i),
        .Ready_o(r2), .Valid_o(v2), .Data_o(d2)
`ifdef RAM_PARITY_EN
       ,.ParityError_o(pe2)
`endif
    );

    int chk = 0;
    int err = 0;
    int edge_cnt = 0;

    typedef struct { logic [31:0] d; int e; } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    // Reference memory: plain word array updated by the rules of the block.
    logic [31:0] ref_mem [1024];

    always @(posedge Clock) edge_cnt++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: pop expected read data whenever a DUT presents Valid_o.
    always @(posedge Clock) begin : mon1
        exp_t x;
        #1;
        if (v1) begin
            chk++;
            if (q1.size() == 0) begin
                err++;
                $display("FAIL l1_unexpected_valid got data %h expected no valid", d1);
            end else begin
                x = q1.pop_front();
                if (d1 !== x.d || edge_cnt != x.e) begin
                    err++;
                    $display("FAIL l1_read got %h @%0d expected %h @%0d", d1, edge_cnt, x.d, x.e);
                end
`ifdef RAM_PARITY_EN
                if (pe1 !== 1'b0) begin
                    err++;
                    $display("FAIL l1_parity got %b expected 0", pe1);
                end
`endif
            end
        end
    end

    always @(posedge Clock) begin : mon2
        exp_t y;
        #1;
        if (v2) begin
            chk++;
            if (q2.size() == 0) begin
                err++;
                $display("FAIL l2_unexpected_valid got data %h expected no valid", d2);
            end else begin
                y = q2.pop_front();
                if (d2 !== y.d || edge_cnt != y.e) begin
                    err++;
                    $display("FAIL l2_read got %h @%0d expected %h @%0d", d2, edge_cnt, y.d, y.e);
                end
`ifdef RAM_PARITY_EN
                if (pe2 !== 1'b0) begin
                    err++;
                    $display("FAIL l2_parity got %b expected 0", pe2);
                end
`endif
            end
        end
    end

    task automatic fill_ref();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hFFFF_FFFF;
    endtask

    // Drive one access at a negedge; the accepting edge is the next posedge.
    task automatic acc(input logic we, input logic [3:0] be, input logic [9:0] a, input logic [31:0] d);
        exp_t x;
        Request_i = 1'b1; WriteEnable_i = we; ByteEnable_i = be; Address_i = a; Data_i = d;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end else begin
            x.d = ref_mem[a];
            x.e = edge_cnt + 1;
            q1.push_back(x);
            x.e = edge_cnt + 2;
            q2.push_back(x);
        end
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        Request_i = 1'b0; Clear_i = 1'b0; WriteEnable_i = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    // Count cycles with Ready_o low; quiet=1 also requires Valid_o=0, Data_o=0.
    task automatic count_low(input bit quiet, output int n, output int bad);
        n = 0; bad = 0;
        #1;
        if (!r1) n = 1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge Clock); #1;
            if (r1 !== r2) bad++;
            if (quiet && (v1 || v2 || d1 !== 32'h0 || d2 !== 32'h0)) bad++;
            if (r1) break;
            n++;
            if (k == 2999) begin
                bad++;
                $display("FAIL ready_timeout got ready low after 3000 cycles expected high");
            end
        end
        Request_i = 1'b0; Clear_i = 1'b0; WriteEnable_i = 1'b0;
    endtask

    initial begin
        int n, bad;
        Reset = 1'b0; Request_i = 1'b0; WriteEnable_i = 1'b0; Clear_i = 1'b0;
        ByteEnable_i = '0; Address_i = '0; Data_i = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

        repeat (3) @(negedge Clock);
        check("reset_ready_l1", {31'b0, r1}, 32'h0);
        check("reset_valid_l1", {31'b0, v1}, 32'h0);
        check("reset_data_l1", d1, 32'h0);
        check("reset_ready_l2", {31'b0, r2}, 32'h0);
        check("reset_data_l2", d2, 32'h0);

        // Release reset with a write and a clear held: both must be ignored in FILL.
        Request_i = 1'b1; WriteEnable_i = 1'b1; ByteEnable_i = 4'hF;
        Address_i = 10'd3; Data_i = 32'h0; Clear_i = 1'b1;
        Reset = 1'b1;
        count_low(1'b1, n, bad);
        check("reset_fill_cycles", n, 1024);
        check("reset_fill_quiet", bad, 0);
        fill_ref();
        @(negedge Clock);

        acc(1'b0, 4'h0, 10'd0, 32'h0);
        acc(1'b0, 4'h0, 10'd1023, 32'h0);
        acc(1'b0, 4'h0, 10'd3, 32'h0);

        // Byte enables, including a no-op write.
        acc(1'b1, 4'b1111, 10'd5, 32'h1122_3344);
        acc(1'b1, 4'b0101, 10'd5, 32'hAABB_CCDD);
        acc(1'b1, 4'b0000, 10'd5, 32'h5555_5555);
        acc(1'b0, 4'h0, 10'd5, 32'h0);
        idle(2);
        check("byte_enable_model", ref_mem[5], 32'h11BB_33DD);

        // Back-to-back reads of distinct values.
        acc(1'b1, 4'hF, 10'd1, 32'h0000_0101);
        acc(1'b1, 4'hF, 10'd2, 32'h0000_0202);
        acc(1'b1, 4'hF, 10'd3, 32'h0000_0303);
        acc(1'b0, 4'h0, 10'd1, 32'h0);
        acc(1'b0, 4'h0, 10'd2, 32'h0);
        acc(1'b0, 4'h0, 10'd3, 32'h0);
        // Read directly after write, same address.
        acc(1'b1, 4'hF, 10'd20, 32'hDEAD_BEEF);
        acc(1'b0, 4'h0, 10'd20, 32'h0);
        idle(3);

        // Random traffic on a small address window to force reuse.
        for (int i = 0; i < 400; i++) begin
            logic [9:0] a;
            a = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) idle(1);
            acc(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
        end
        idle(4);

        // Clear with a simultaneous read: the read sees pre-fill data.
        acc(1'b1, 4'hF, 10'd7, 32'h0);
        Clear_i = 1'b1;
        acc(1'b0, 4'h0, 10'd7, 32'h0);
        count_low(1'b0, n, bad);
        check("clear_fill_cycles", n, 1024);
        check("clear_fill_ready_match", bad, 0);
        fill_ref();
        @(negedge Clock);
        acc(1'b0, 4'h0, 10'd7, 32'h0);
        acc(1'b0, 4'h0, 10'd15, 32'h0);
        idle(4);

        // Reset in the middle of a fill pass.
        Clear_i = 1'b1;
        @(negedge Clock);
        Clear_i = 1'b0;
        repeat (500) @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("midfill_reset_ready", {31'b0, r1}, 32'h0);
        check("midfill_reset_data_l1", d1, 32'h0);
        check("midfill_reset_data_l2", d2, 32'h0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        count_low(1'b1, n, bad);
        check("midfill_refill_cycles", n, 1024);
        check("midfill_refill_quiet", bad, 0);
        fill_ref();
        @(negedge Clock);
        acc(1'b0, 4'h0, 10'd100, 32'h0);
        acc(1'b0, 4'h0, 10'd900, 32'h0);
        idle(6);

        check("l1_queue_drained", q1.size(), 0);
        check("l2_queue_drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule

// File: doc/ram_sp_fill.md
Name: ram_sp_fill

Overview:
Single-port synchronous RAM, the parametrised successor to the basic byte RAM.
- Adds per-byte write enables, a selectable read pipeline depth and a read-valid strobe.
- Adds a hardware fill engine that initialises every word to a programmable value after reset or on request.
- Used as a general data/scratch memory behind bus adapters and DMA engines.

Parameters:
ADDRESS_WIDTH, 10, word address width; depth = 2**ADDRESS_WIDTH words.
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
READ_LATENCY, 1, cycles from accepted read to Valid_o; legal values 1 or 2.
FILL_VALUE, 32'hFFFF_FFFF, value written to every word by the fill engine (truncated to DATA_WIDTH).

Ports:
Clock  input  1  system clock, all logic on rising edge.
Reset  input  1  asynchronous, active-low reset.
Request_i  input  1  access request, sampled when Ready_o=1.
WriteEnable_i  input  1  1 = write, 0 = read, qualified by Request_i.
ByteEnable_i  input  DATA_WIDTH/8  per-byte write mask; ignored for reads.
Address_i  input  ADDRESS_WIDTH  word address.
Data_i  input  DATA_WIDTH  write data.
Clear_i  input  1  single-cycle pulse; starts a fill pass.
Ready_o  output  1  1 = idle and accepting requests.
Valid_o  output  1  one-cycle strobe, Data_o carries read data.
Data_o  output  DATA_WIDTH  read data, held until the next read completes.
ParityError_o  output  1  present only with RAM_PARITY_EN.

Behaviour:
Reset and outputs
- Reset low forces Ready_o=0, Valid_o=0, Data_o=0, ParityError_o=0, flushes the read pipeline and sets FSM=FILL with fill counter=0.

States
- FILL
  - Each cycle writes FILL_VALUE (all bytes) to the address held in the fill counter, then increments the counter.
  - After writing address 2**ADDRESS_WIDTH-1, the next state is IDLE.
  - A full pass is exactly 2**ADDRESS_WIDTH cycles after reset release.
  - Request_i and Clear_i are ignored in FILL.
- IDLE
  - Ready_o=1.
  - Request_i=1 is accepted on that edge, with back-to-back accesses every cycle.
  - Clear_i=1 in IDLE moves to FILL on the next edge. The counter restarts at 0 and Ready_o=0 from that edge.
  - If Request_i and Clear_i are both 1, the request is accepted first, then FILL starts.

Write
- For each byte lane with its ByteEnable_i bit set, Memory[Address_i] takes Data_i on the accepting edge.
- Unmasked lanes are unchanged.
- ByteEnable_i=0 is a legal no-op write.
- Writes produce no Valid_o.

Read
- READ_LATENCY=1: Data_o is updated and Valid_o=1 on the accepting edge (visible the cycle after the request).
- READ_LATENCY=2: one extra register stage, so data and Valid_o appear one cycle later.
- Reads in flight when FILL starts via Clear_i still complete with the pre-fill data.

Collisions and boundaries
- Read-during-write at the same address in consecutive cycles returns the newly written data.
- Address wrap: none needed; Address_i is always in range.
- Reset asserted mid-fill aborts the pass; the fill restarts from address 0 after release.

Optional Feature:
RAM_PARITY_EN
- Defined:
  - Each byte lane stores an extra even-parity bit, computed on every write, including fill writes.
  - On reads, parity is checked in the same stage that drives Data_o.
  - ParityError_o pulses with Valid_o when any byte mismatches.
  - ParityError_o resets to 0.
- Undefined:
  - No parity storage.
  - The ParityError_o port does not exist.

Test Plan:
- Reset fill: release Reset with defaults -> Ready_o low for exactly 1024 cycles. Then read address 0 and address 1023 -> Data_o=32'hFFFF_FFFF with Valid_o one cycle later.
- Byte enables: write 32'h1122_3344 BE=4'b1111 to address 5, then 32'hAABB_CCDD BE=4'b0101, then read address 5 -> 32'h11BB_33DD.
- Latency: READ_LATENCY=2, back-to-back reads of addresses 1, 2, 3 holding distinct values -> three consecutive Valid_o pulses starting 2 cycles after the first request, data in order.
- Clear: write 32'h0 to address 7, pulse Clear_i -> Ready_o=0 for 1024 cycles, then a read of address 7 returns 32'hFFFF_FFFF.
- Reset mid-fill: assert Reset at fill cycle 500, release -> Ready_o stays 0 for a full 1024 cycles; Data_o=0 and Valid_o=0 throughout.
- Parity (RAM_PARITY_EN): write 32'h0000_0001 to address 9, force-flip a stored data bit through the hierarchy, then read -> ParityError_o=1 coincident with Valid_o. A clean word read returns ParityError_o=0.
